// File: rtl/pic_pkg.sv
// ---------------------------------------------------------------------------
// pic_pkg
//
// Shared definitions for the PIC interrupt-acknowledge path: the sequencer
// state encoding, the vector-byte selector codes that tell the data-bus buffer
// which byte to place on the bus, the level reported for a spurious
// acknowledge, and the SP/EN mode encodings.
// ---------------------------------------------------------------------------
package pic_pkg;

    // INTA sequencer states.
    // PEND: a request is being raised to the CPU.
    // Px: an INTA pulse is low. Gx: the gap after pulse x.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PEND = 3'd1,
        ST_P1   = 3'd2,
        ST_G1   = 3'd3,
        ST_P2   = 3'd4,
        ST_G2   = 3'd5,
        ST_P3   = 3'd6
    } seq_state_e;

    // Vector byte selector seen by the data-bus buffer.
    localparam logic [1:0] BSEL_VEC  = 2'd0;  // x86 8-bit vector
    localparam logic [1:0] BSEL_CALL = 2'd1;  // 8080 CALL opcode
    localparam logic [1:0] BSEL_LO   = 2'd2;  // 8080 routine address, low
    localparam logic [1:0] BSEL_HI   = 2'd3;  // 8080 routine address, high

    // Level reported when the request vanished before the acknowledge.
    localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;

    // Value of the sp input for each role.
    localparam logic MODE_MASTER = 1'b1;
    localparam logic MODE_SLAVE  = 1'b0;

endpackage

// File: rtl/inta_edge_detect.sv
// ---------------------------------------------------------------------------
// inta_edge_detect
//
// Registers the (already synchronised) INTA strobe once and produces
// single-cycle fall/rise pulses in the cycle the new level is first seen.
// Also used by the data-bus buffer logic.
//
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   inta_n_i INTA strobe, active low, synchronous to clk
//   fall_o   1 for the cycle where inta_n goes 1 -> 0
//   rise_o   1 for the cycle where inta_n goes 0 -> 1
// ---------------------------------------------------------------------------
module inta_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic inta_n_i,
    output logic fall_o,
    output logic rise_o
);

    logic inta_q;

    // Resets to the idle (high) level so no edge is reported coming out of
    // reset while the strobe is inactive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inta_q <= 1'b1;
        end else begin
            inta_q <= inta_n_i;
        end
    end

    assign fall_o = inta_q & ~inta_n_i;
    assign rise_o = ~inta_q & inta_n_i;

endmodule

// File: rtl/cascade_inta_sequencer.sv
// ---------------------------------------------------------------------------
// cascade_inta_sequencer
//
// Sequences the CPU interrupt-acknowledge cycle for the PIC. Raises int_o for
// a pending request, counts INTA pulses (2 in x86 mode, 3 in 8080 mode),
// latches the serviced level and pulses isr_set, drives the cascade lines as
// a master with a slave on the serviced level, decodes the cascade lines as a
// slave, and tells the data-bus buffer whether this device drives the current
// vector byte and which byte that is. A gap between pulses longer than
// GAP_TIMEOUT cycles aborts the sequence.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   inta_n            INTA strobe, active low, synchronised to clk
//   req_valid         priority resolver has a winning level
//   req_level         winning IR level
//   sp                1 = master, 0 = slave
//   icw3              master: slave-present mask; slave: [2:0] = own ID
//   sngl              single mode (no cascading)
//   upm               1 = x86 (2 pulses), 0 = 8080 (3 pulses)
//   cas_in            sampled cascade lines
//   int_o             interrupt request to the CPU
//   cas_out, cas_oe   cascade value and pad enable
//   data_oe, byte_sel this PIC drives the current vector byte / which byte
//   isr_set           one-cycle pulse: set ISR bit isr_level
//   isr_level         latched serviced level
//   seq_done          one-cycle pulse on the rise of the final pulse
//   seq_abort         one-cycle pulse on gap timeout
//
// Optional (macro PIC_AUTO_EOI_EN):
//   aeoi              automatic end-of-interrupt enable
//   isr_clr           one-cycle pulse the cycle after seq_done
//   isr_clr_level     level to clear
// ---------------------------------------------------------------------------
module cascade_inta_sequencer
    import pic_pkg::*;
#(
    parameter int GAP_TIMEOUT = 64,
    parameter int TO_W        = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inta_n,
    input  logic       req_valid,
    input  logic [2:0] req_level,
    input  logic       sp,
    input  logic [7:0] icw3,
    input  logic       sngl,
    input  logic       upm,
    input  logic [2:0] cas_in,
    output logic       int_o,
    output logic [2:0] cas_out,
    output logic       cas_oe,
    output logic       data_oe,
    output logic [1:0] byte_sel,
    output logic       isr_set,
    output logic [2:0] isr_level,
    output logic       seq_done,
    output logic       seq_abort
`ifdef PIC_AUTO_EOI_EN
    ,
    input  logic       aeoi,
    output logic       isr_clr,
    output logic [2:0] isr_clr_level
`endif
);

    // Gap counter value during the last permitted gap cycle.
    localparam logic [TO_W-1:0] GAP_LAST = TO_W'(GAP_TIMEOUT - 1);

    logic            fall;
    logic            rise;
    seq_state_e      state_q;
    seq_state_e      state_d;
    logic [TO_W-1:0] gap_cnt_q;
    logic [TO_W-1:0] gap_cnt_d;

    // Context captured when the first pulse starts.
    logic [2:0]      level_q;
    logic            cascaded_q;
    logic            match_q;
    logic            sp_q;
    logic            upm_q;
    logic            isr_set_q;

    logic            start;
    logic [2:0]      start_level;
    logic            start_cascaded;
    logic            start_match;
    logic            in_gap;
    logic            gap_expired;
    logic            owner;
    logic            cas_active;

    // -----------------------------------------------------------------------
    // INTA edge detection
    // -----------------------------------------------------------------------
    inta_edge_detect u_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .inta_n_i (inta_n),
        .fall_o   (fall),
        .rise_o   (rise)
    );

    // -----------------------------------------------------------------------
    // Sequence start decisions, evaluated in the cycle of the first fall
    // -----------------------------------------------------------------------
    // A fall is only treated as the first pulse from IDLE or PEND; later
    // changes on req_valid/req_level cannot disturb a running sequence.
    assign start          = fall & ((state_q == ST_IDLE) | (state_q == ST_PEND));
    assign start_level    = req_valid ? req_level : SPURIOUS_LEVEL;
    assign start_cascaded = (sp == MODE_MASTER) & ~sngl & icw3[start_level];
    assign start_match    = sngl | (cas_in == icw3[2:0]);

    // Master drives unless a slave owns the level; slave drives on ID match.
    assign owner = (sp_q == MODE_MASTER) ? ~cascaded_q : match_q;

    assign in_gap      = (state_q == ST_G1) | (state_q == ST_G2);
    // A fall in the last permitted gap cycle still wins over the timeout.
    assign gap_expired = in_gap & ~fall & (gap_cnt_q == GAP_LAST);

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    state_d = ST_P1;
                end else if (req_valid) begin
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                if (fall) begin
                    state_d = ST_P1;
                end else if (!req_valid) begin
                    state_d = ST_IDLE;
                end
            end
            ST_P1: begin
                if (rise) begin
                    state_d = ST_G1;
                end
            end
            ST_G1: begin
                if (fall) begin
                    state_d = ST_P2;
                end else if (gap_expired) begin
                    state_d = ST_IDLE;
                end
            end
            ST_P2: begin
                if (rise) begin
                    state_d = upm_q ? ST_IDLE : ST_G2;
                end
            end
            ST_G2: begin
                if (fall) begin
                    state_d = ST_P3;
                end else if (gap_expired) begin
                    state_d = ST_IDLE;
                end
            end
            ST_P3: begin
                if (rise) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------------
    always_comb begin
        int_o      = 1'b0;
        data_oe    = 1'b0;
        byte_sel   = BSEL_VEC;
        cas_active = 1'b0;
        seq_done   = 1'b0;
        seq_abort  = 1'b0;
        case (state_q)
            ST_PEND: begin
                // Withdrawn in the very cycle the CPU starts acknowledging.
                int_o = ~fall;
            end
            ST_P1: begin
                cas_active = 1'b1;
                if (!upm_q) begin
                    // Only an uncascaded master supplies the CALL opcode.
                    byte_sel = BSEL_CALL;
                    data_oe  = (sp_q == MODE_MASTER) & ~cascaded_q & ~rise;
                end
            end
            ST_G1, ST_G2: begin
                cas_active = ~gap_expired;
                seq_abort  = gap_expired;
            end
            ST_P2: begin
                byte_sel = upm_q ? BSEL_VEC : BSEL_LO;
                data_oe  = owner & ~rise;
                // In x86 mode this is the final pulse.
                seq_done   = upm_q & rise;
                cas_active = ~(upm_q & rise);
            end
            ST_P3: begin
                byte_sel   = BSEL_HI;
                data_oe    = owner & ~rise;
                seq_done   = rise;
                cas_active = ~rise;
            end
            default: begin
            end
        endcase
    end

    assign cas_oe    = cas_active & cascaded_q;
    assign cas_out   = cas_oe ? level_q : 3'd0;
    assign isr_set   = isr_set_q;
    assign isr_level = level_q;

    // -----------------------------------------------------------------------
    // Sequence context
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q    <= 3'd0;
            cascaded_q <= 1'b0;
            match_q    <= 1'b0;
            sp_q       <= 1'b0;
            upm_q      <= 1'b0;
            isr_set_q  <= 1'b0;
        end else begin
            // A spurious acknowledge must not mark any level in service.
            isr_set_q <= start & req_valid;
            if (start) begin
                level_q    <= start_level;
                cascaded_q <= start_cascaded;
                match_q    <= start_match;
                sp_q       <= sp;
                upm_q      <= upm;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Gap timeout counter: counts gap cycles, clears on a fall or outside
    // the gap states.
    // -----------------------------------------------------------------------
    always_comb begin
        gap_cnt_d = '0;
        if (in_gap && !fall && !gap_expired) begin
            gap_cnt_d = gap_cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt_q <= '0;
        end else begin
            gap_cnt_q <= gap_cnt_d;
        end
    end

`ifdef PIC_AUTO_EOI_EN
    // -----------------------------------------------------------------------
    // Automatic EOI: clear the serviced bit one cycle after seq_done
    // -----------------------------------------------------------------------
    logic spurious_q;
    logic isr_clr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spurious_q <= 1'b0;
            isr_clr_q  <= 1'b0;
        end else begin
            if (start) begin
                spurious_q <= ~req_valid;
            end
            isr_clr_q <= seq_done & aeoi & ~spurious_q;
        end
    end

    assign isr_clr       = isr_clr_q;
    assign isr_clr_level = level_q;
`endif

endmodule

// File: tb/tb_cascade_inta_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for cascade_inta_sequencer. Expected values come from the
// acknowledge rules (level, cascade/ownership decision, per-pulse byte
// schedule) computed per transaction.
// ---------------------------------------------------------------------------
module tb_cascade_inta_sequencer;

    logic       clk;
    logic       rst_n;
    logic       inta_n;
    logic       req_valid;
    logic [2:0] req_level;
    logic       sp;
    logic [7:0] icw3;
    logic       sngl;
    logic       upm;
    logic [2:0] cas_in;
    logic       int_o;
    logic [2:0] cas_out;
    logic       cas_oe;
    logic       data_oe;
    logic [1:0] byte_sel;
    logic       isr_set;
    logic [2:0] isr_level;
    logic       seq_done;
    logic       seq_abort;
`ifdef PIC_AUTO_EOI_EN
    logic       aeoi;
    logic       isr_clr;
    logic [2:0] isr_clr_level;
`endif

    int checks;
    int failures;

    cascade_inta_sequencer #(.GAP_TIMEOUT(64), .TO_W(7)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .inta_n    (inta_n),
        .req_valid (req_valid),
        .req_level (req_level),
        .sp        (sp),
        .icw3      (icw3),
        .sngl      (sngl),
        .upm       (upm),
        .cas_in    (cas_in),
        .int_o     (int_o),
        .cas_out   (cas_out),
        .cas_oe    (cas_oe),
        .data_oe   (data_oe),
        .byte_sel  (byte_sel),
        .isr_set   (isr_set),
        .isr_level (isr_level),
        .seq_done  (seq_done),
        .seq_abort (seq_abort)
`ifdef PIC_AUTO_EOI_EN
        ,
        .aeoi          (aeoi),
        .isr_clr       (isr_clr),
        .isr_clr_level (isr_clr_level)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One full acknowledge sequence with reference expectations.
    task automatic run_seq(input logic t_sp, input logic t_upm, input logic t_sngl,
                           input logic [7:0] t_icw3, input logic [2:0] t_cas,
                           input logic [2:0] t_level, input logic t_spur,
                           input logic t_aeoi, input int t_width, input int t_gap,
                           input string tag);
        logic [2:0] exp_lvl;
        logic       casc;
        logic       match;
        logic       owner;
        logic       ed;
        logic [1:0] eb;
        int         np;
        exp_lvl = t_spur ? 3'd7 : t_level;
        casc    = t_sp & ~t_sngl & t_icw3[exp_lvl];
        match   = t_sngl | (t_cas == t_icw3[2:0]);
        owner   = t_sp ? ~casc : match;
        np      = t_upm ? 2 : 3;
        $display("seq %s sp=%0d upm=%0d sngl=%0d icw3=%02h cas_in=%0d lvl=%0d spur=%0d -> casc=%0d owner=%0d",
                 tag, t_sp, t_upm, t_sngl, t_icw3, t_cas, exp_lvl, t_spur, casc, owner);

        @(posedge clk); #1;
        sp = t_sp; upm = t_upm; sngl = t_sngl; icw3 = t_icw3; cas_in = t_cas;
        req_valid = 1'b1; req_level = t_level; inta_n = 1'b1;
`ifdef PIC_AUTO_EOI_EN
        aeoi = t_aeoi;
`endif
        @(negedge clk);
        checks++;
        if (int_o !== 1'b0) begin failures++; $display("FAIL %s int_o_idle got=%0b exp=0", tag, int_o); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (int_o !== 1'b1) begin failures++; $display("FAIL %s int_o_pend got=%0b exp=1", tag, int_o); end

        for (int p = 1; p <= np; p++) begin
            ed = t_upm ? ((p == 2) ? owner : 1'b0) : ((p == 1) ? (t_sp & ~casc) : owner);
            eb = t_upm ? 2'd0 : 2'(p);
            // fall cycle
            @(posedge clk); #1;
            inta_n = 1'b0;
            if (p == 1 && t_spur) req_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (int_o !== 1'b0) begin failures++; $display("FAIL %s int_o_fall p%0d got=%0b exp=0", tag, p, int_o); end
            checks++;
            if (cas_oe !== ((p == 1) ? 1'b0 : casc)) begin
                failures++; $display("FAIL %s cas_oe_fall p%0d got=%0b exp=%0b", tag, p, cas_oe, (p == 1) ? 1'b0 : casc);
            end
            // cycles with the pulse low
            for (int w = 1; w <= t_width; w++) begin
                @(posedge clk); #1;
                req_level = 3'($urandom);
                @(negedge clk);
                checks++;
                if (isr_set !== ((p == 1 && w == 1) ? ~t_spur : 1'b0)) begin
                    failures++; $display("FAIL %s isr_set p%0d w%0d got=%0b exp=%0b", tag, p, w, isr_set, (p == 1 && w == 1) ? ~t_spur : 1'b0);
                end
                checks++;
                if (isr_level !== exp_lvl) begin failures++; $display("FAIL %s isr_level got=%0d exp=%0d", tag, isr_level, exp_lvl); end
                checks++;
                if (data_oe !== ed) begin failures++; $display("FAIL %s data_oe p%0d got=%0b exp=%0b", tag, p, data_oe, ed); end
                if (ed) begin
                    checks++;
                    if (byte_sel !== eb) begin failures++; $display("FAIL %s byte_sel p%0d got=%0d exp=%0d", tag, p, byte_sel, eb); end
                end
                checks++;
                if (cas_oe !== casc) begin failures++; $display("FAIL %s cas_oe_pulse p%0d got=%0b exp=%0b", tag, p, cas_oe, casc); end
                if (casc) begin
                    checks++;
                    if (cas_out !== exp_lvl) begin failures++; $display("FAIL %s cas_out got=%0d exp=%0d", tag, cas_out, exp_lvl); end
                end
            end
            // rise cycle
            @(posedge clk); #1;
            inta_n = 1'b1;
            if (p == np) req_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (data_oe !== 1'b0) begin failures++; $display("FAIL %s data_oe_rise p%0d got=%0b exp=0", tag, p, data_oe); end
            checks++;
            if (seq_done !== (p == np)) begin failures++; $display("FAIL %s seq_done p%0d got=%0b exp=%0b", tag, p, seq_done, p == np); end
            checks++;
            if (cas_oe !== ((p == np) ? 1'b0 : casc)) begin
                failures++; $display("FAIL %s cas_oe_rise p%0d got=%0b exp=%0b", tag, p, cas_oe, (p == np) ? 1'b0 : casc);
            end
`ifdef PIC_AUTO_EOI_EN
            checks++;
            if (isr_clr !== 1'b0) begin failures++; $display("FAIL %s isr_clr_early got=%0b exp=0", tag, isr_clr); end
`endif
            // gap cycles
            if (p < np) begin
                for (int g = 1; g <= t_gap; g++) begin
                    @(posedge clk); #1;
                    @(negedge clk);
                    checks++;
                    if (cas_oe !== casc || data_oe !== 1'b0 || seq_abort !== 1'b0) begin
                        failures++;
                        $display("FAIL %s gap p%0d g%0d cas_oe/data_oe/abort got=%0b%0b%0b exp=%0b00", tag, p, g, cas_oe, data_oe, seq_abort, casc);
                    end
                end
            end
        end
        // first idle cycle
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (seq_done !== 1'b0 || cas_oe !== 1'b0 || int_o !== 1'b0) begin
            failures++; $display("FAIL %s post done/cas_oe/int_o got=%0b%0b%0b exp=000", tag, seq_done, cas_oe, int_o);
        end
`ifdef PIC_AUTO_EOI_EN
        checks++;
        if (isr_clr !== (t_aeoi & ~t_spur)) begin
            failures++; $display("FAIL %s isr_clr got=%0b exp=%0b", tag, isr_clr, t_aeoi & ~t_spur);
        end
        if (t_aeoi & ~t_spur) begin
            checks++;
            if (isr_clr_level !== exp_lvl) begin failures++; $display("FAIL %s isr_clr_level got=%0d exp=%0d", tag, isr_clr_level, exp_lvl); end
        end
`else
        if (t_aeoi) begin end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({int_o, cas_out, cas_oe, data_oe, byte_sel, isr_set, isr_level, seq_done, seq_abort} !== 14'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=0", {int_o, cas_out, cas_oe, data_oe, byte_sel, isr_set, isr_level, seq_done, seq_abort});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        $display("reset released");
    endtask

    task automatic test_pend_withdraw();
        @(posedge clk); #1;
        sp = 1'b1; upm = 1'b1; sngl = 1'b0; icw3 = 8'h00; req_valid = 1'b1; req_level = 3'd5;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (int_o !== 1'b1) begin failures++; $display("FAIL withdraw int_o_pend got=%0b exp=1", int_o); end
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (int_o !== 1'b0 || isr_set !== 1'b0) begin
            failures++; $display("FAIL withdraw int_o/isr_set got=%0b%0b exp=00", int_o, isr_set);
        end
        $display("withdraw request before acknowledge");
    endtask

    task automatic test_x86_master();
        run_seq(1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 3'd3, 1'b0, 1'b1, 2, 2, "x86_master");
    endtask

    task automatic test_x86_cascaded();
        run_seq(1'b1, 1'b1, 1'b0, 8'h04, 3'd0, 3'd2, 1'b0, 1'b0, 2, 3, "x86_cascade");
    endtask

    task automatic test_slave_8080();
        run_seq(1'b0, 1'b0, 1'b0, 8'h05, 3'd5, 3'd1, 1'b0, 1'b1, 2, 2, "slave_match");
        run_seq(1'b0, 1'b0, 1'b0, 8'h05, 3'd4, 3'd1, 1'b0, 1'b0, 2, 2, "slave_nomatch");
        run_seq(1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 3'd6, 1'b0, 1'b0, 1, 1, "master_8080");
    endtask

    task automatic test_spurious();
        run_seq(1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 3'd4, 1'b1, 1'b1, 1, 1, "spurious");
    endtask

    task automatic test_timeout();
        logic [2:0] lvl;
        lvl = 3'($urandom);
        @(posedge clk); #1;
        sp = 1'b1; upm = 1'b1; sngl = 1'b0; icw3 = 8'hFF; req_valid = 1'b1; req_level = lvl;
        @(posedge clk); #1;
        inta_n = 1'b0;
        @(posedge clk); #1;
        inta_n = 1'b1;
        @(negedge clk);
        for (int g = 1; g <= 64; g++) begin
            @(posedge clk); #1;
            @(negedge clk);
            checks++;
            if (seq_abort !== (g == 64)) begin failures++; $display("FAIL timeout abort g%0d got=%0b exp=%0b", g, seq_abort, g == 64); end
            if (g < 64) begin
                checks++;
                if (cas_oe !== 1'b1) begin failures++; $display("FAIL timeout cas_oe g%0d got=%0b exp=1", g, cas_oe); end
            end
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (seq_abort !== 1'b0 || cas_oe !== 1'b0 || int_o !== 1'b0) begin
            failures++; $display("FAIL timeout after abort/cas_oe/int_o got=%0b%0b%0b exp=000", seq_abort, cas_oe, int_o);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (int_o !== 1'b1) begin failures++; $display("FAIL timeout repend int_o got=%0b exp=1", int_o); end
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        $display("timeout lvl=%0d aborted after 64 gap cycles", lvl);
    endtask

    task automatic test_async_reset();
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            sp = 1'b1; upm = 1'b1; sngl = 1'b0; icw3 = (c == 1) ? 8'hFF : 8'h00;
            req_valid = 1'b1; req_level = 3'd4;
            @(posedge clk); #1; inta_n = 1'b0;
            @(posedge clk); #1; inta_n = 1'b1;
            @(posedge clk); #1; inta_n = 1'b0;
            @(posedge clk); #1;
            @(negedge clk);
            checks++;
            if (cas_oe !== 1'(c) || data_oe !== 1'(1 - c)) begin
                failures++; $display("FAIL areset pre c%0d cas_oe/data_oe got=%0b%0b exp=%0b%0b", c, cas_oe, data_oe, 1'(c), 1'(1 - c));
            end
            #2;
            rst_n = 1'b0;
            #1;
            checks++;
            if (cas_oe !== 1'b0 || data_oe !== 1'b0 || int_o !== 1'b0 || isr_level !== 3'd0) begin
                failures++; $display("FAIL areset c%0d cas_oe/data_oe/int_o/isr_level got=%0b%0b%0b%0d exp=0000", c, cas_oe, data_oe, int_o, isr_level);
            end
            inta_n = 1'b1; req_valid = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            @(posedge clk); #1;
            $display("async reset in P2 cascaded=%0d", c);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            run_seq(1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                    8'($urandom), 3'($urandom), 3'($urandom),
                    ($urandom_range(0, 4) == 0), 1'($urandom),
                    $urandom_range(1, 3), $urandom_range(0, 4), "random");
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0; inta_n = 1'b1; req_valid = 1'b0; req_level = 3'd0;
        sp = 1'b1; icw3 = 8'h00; sngl = 1'b0; upm = 1'b1; cas_in = 3'd0;
`ifdef PIC_AUTO_EOI_EN
        aeoi = 1'b0;
`endif
        test_reset();
        test_pend_withdraw();
        test_x86_master();
        test_x86_cascaded();
        test_slave_8080();
        test_spurious();
        test_timeout();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
